// File: rtl/ram16k_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram16k_arbiter : two-port arbiter serialising single-word accesses onto one
// external RAM16K. Optional macro ARB_FIXED_PRIO_EN selects fixed priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ram16k_arbiter #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  output logic                     ack0,
  output logic [DATA_WIDTH-1:0]    rdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     ack1,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_in,
  output logic                     ram_load,
  input  logic [DATA_WIDTH-1:0]    ram_out,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

  logic                    w_pick;
  logic                    w_sel_we;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick = ~req0;
`else
  // Last-served port; on a tie the other port wins.
  logic last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (state_q == SERVE) begin
      last_q <= grant_q;
    end
  end

  assign w_pick = (req0 && req1) ? ~last_q : req1;
`endif

  assign w_sel_we    = grant_q ? we1    : we0;
  assign w_sel_addr  = grant_q ? addr1  : addr0;
  assign w_sel_wdata = grant_q ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // RAM drive stays combinational so a write in SERVE commits even under reset.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = w_pick;
          state_d = SERVE;
        end
      end
      SERVE: begin
        ram_address = w_sel_addr;
        ram_in      = w_sel_wdata;
        ram_load    = w_sel_we;
        if (grant_q) begin
          ack1_d = 1'b1;
          if (!w_sel_we) rdata1_d = ram_out;
        end else begin
          ack0_d = 1'b1;
          if (!w_sel_we) rdata0_d = ram_out;
        end
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q == SERVE) || (state_q == DONE);

endmodule
`default_nettype wire
